// File: rtl/pwm_pkg.sv
// Shared constants for the PWM configuration register block:
// register map, CTRL/STATUS bit positions and frame FSM states.
package pwm_pkg;

  localparam logic [6:0] ADDR_CTRL      = 7'h00;
  localparam logic [6:0] ADDR_CH_EN     = 7'h01;
  localparam logic [6:0] ADDR_PERIOD    = 7'h02;
  localparam logic [6:0] ADDR_STATUS    = 7'h03;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;
  localparam logic [6:0] ADDR_ID        = 7'h7F;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_COMMIT  = 7;
  localparam int STAT_PENDING = 0;
  localparam int STAT_ERROR   = 1;
  localparam int CMD_READ     = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } frame_state_t;

  function automatic logic is_duty(
    input logic [6:0] a,
    input int         n
  );
    return (a[6:3] == ADDR_DUTY_BASE[6:3]) &&
           (int'(a[2:0]) < n);
  endfunction

endpackage

// File: rtl/pwm_cfg_regs_if.sv
// Byte-level link between the SPI deserializer (master)
// and the configuration register block (slave).
interface pwm_cfg_regs_if;

  logic       spi_ncs_i;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;

  modport master (
    output spi_ncs_i,
    output rx_valid_i,
    output rx_data_i,
    input  tx_data_o,
    input  tx_valid_o
  );

  modport slave (
    input  spi_ncs_i,
    input  rx_valid_i,
    input  rx_data_i,
    output tx_data_o,
    output tx_valid_o
  );

endinterface

// File: rtl/pwm_cfg_frame_fsm.sv
// Two-byte SPI frame decoder: latches command, emits
// read strobe after the command byte and write strobe after data.
module pwm_cfg_frame_fsm
  import pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ncs,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rd_stb,
  output logic [6:0] rd_addr,
  output logic       wr_stb,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data
);

  frame_state_t state;
  frame_state_t state_n;
  logic [6:0]   addr_q;
  logic         rd_q;
  logic         latch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      rd_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (latch) begin
        addr_q <= rx_data[6:0];
        rd_q   <= rx_data[CMD_READ];
      end
    end
  end

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    rd_stb  = 1'b0;
    wr_stb  = 1'b0;
    if (ncs) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_n = ST_CMD;
        ST_CMD: begin
          if (rx_valid) begin
            state_n = ST_DATA;
            latch   = 1'b1;
            rd_stb  = rx_data[CMD_READ];
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            state_n = ST_DONE;
            wr_stb  = !rd_q;
          end
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign rd_addr = rx_data[6:0];
  assign wr_addr = addr_q;
  assign wr_data = rx_data;

endmodule

// File: rtl/pwm_cfg_regs.sv
// PWM configuration registers: shadow copies written over SPI,
// committed atomically to the active outputs at a period boundary.
module pwm_cfg_regs
  import pwm_pkg::*;
#(
  parameter int         PWM_INSTANCES = 1,
  parameter logic [7:0] ID_VALUE      = 8'hA5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  pwm_cfg_regs_if.slave              bus,
  input  logic                       period_end_i,
  output logic                       enable_o,
  output logic [PWM_INSTANCES-1:0]   ch_en_o,
  output logic [7:0]                 period_o,
  output logic [8*PWM_INSTANCES-1:0] duty_o,
  output logic                       update_o
);

  localparam int N = PWM_INSTANCES;

  logic       rd_stb;
  logic       wr_stb;
  logic [6:0] rd_addr;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  pwm_cfg_frame_fsm u_fsm (
    .clk      (clk_i),
    .rst      (rst_i),
    .ncs      (bus.spi_ncs_i),
    .rx_valid (bus.rx_valid_i),
    .rx_data  (bus.rx_data_i),
    .rd_stb   (rd_stb),
    .rd_addr  (rd_addr),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  logic         sh_en;
  logic [N-1:0] sh_ch_en;
  logic [7:0]   sh_period;
  logic [7:0]   sh_duty [8];
  logic         pending;
  logic         error;
  logic [7:0]   tx_data_q;
  logic         tx_valid_q;

  logic [6:0] acc_addr;
  logic       hit_ctrl;
  logic       hit_ch_en;
  logic       hit_period;
  logic       hit_status;
  logic       hit_duty;
  logic       hit_id;
  logic       hit_any;
  logic [7:0] rd_val;
  logic       commit_req;
  logic       commit_fire;
  logic       bad_acc;
  logic       clr_err;

  assign acc_addr = rd_stb ? rd_addr : wr_addr;

  always_comb begin
    hit_ctrl   = (acc_addr == ADDR_CTRL);
    hit_ch_en  = (acc_addr == ADDR_CH_EN);
    hit_period = (acc_addr == ADDR_PERIOD);
    hit_status = (acc_addr == ADDR_STATUS);
    hit_duty   = is_duty(acc_addr, N);
    hit_id     = (acc_addr == ADDR_ID);
    hit_any    = hit_ctrl | hit_ch_en | hit_period |
                 hit_status | hit_duty | hit_id;
  end

  // Reads always return shadow state, never the active copy.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      hit_ctrl:   rd_val[CTRL_ENABLE] = sh_en;
      hit_ch_en:  rd_val[N-1:0] = sh_ch_en;
      hit_period: rd_val = sh_period;
      hit_status: begin
        rd_val[STAT_PENDING] = pending;
        rd_val[STAT_ERROR]   = error;
      end
      hit_duty:   rd_val = sh_duty[acc_addr[2:0]];
      hit_id:     rd_val = ID_VALUE;
      default:    rd_val = '0;
    endcase
  end

  assign commit_req  = wr_stb & hit_ctrl & wr_data[CTRL_COMMIT];
  assign commit_fire = pending & (period_end_i | ~enable_o);
  assign bad_acc     = (rd_stb | wr_stb) & ~hit_any;
  assign clr_err     = rd_stb & hit_status;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_en     <= 1'b0;
      sh_ch_en  <= '0;
      sh_period <= '0;
      for (int i = 0; i < 8; i++) begin
        sh_duty[i] <= '0;
      end
    end else if (wr_stb) begin
      unique case (1'b1)
        hit_ctrl:   sh_en <= wr_data[CTRL_ENABLE];
        hit_ch_en:  sh_ch_en <= wr_data[N-1:0];
        hit_period: sh_period <= wr_data;
        hit_duty:   sh_duty[acc_addr[2:0]] <= wr_data;
        default:    ;
      endcase
    end
  end

  // Active copy samples the pre-write shadow on a collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_o <= 1'b0;
      ch_en_o  <= '0;
      period_o <= '0;
      duty_o   <= '0;
      update_o <= 1'b0;
    end else begin
      update_o <= commit_fire;
      if (commit_fire) begin
        enable_o <= sh_en;
        ch_en_o  <= sh_ch_en;
        period_o <= sh_period;
        for (int n = 0; n < N; n++) begin
          duty_o[8*n +: 8] <= sh_duty[n];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending    <= 1'b0;
      error      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      pending    <= commit_req | (pending & ~commit_fire);
      error      <= bad_acc | (error & ~clr_err);
      tx_valid_q <= rd_stb;
      if (rd_stb) begin
        tx_data_q <= rd_val;
      end
    end
  end

  assign bus.tx_data_o  = tx_data_q;
  assign bus.tx_valid_o = tx_valid_q;

endmodule
